// File: rtl/fpu_defs.sv
// Shared FPU definitions: operand/flag widths and dispatch buffer types.
package fpu_defs;

    localparam int unsigned C_OP                 = 32;
    localparam int unsigned C_FFLAG              = 5;
    localparam int unsigned C_DISPATCH_UNITS_MAX = 8;
    localparam int unsigned C_DISPATCH_TAG_W     = 5;

    // One dispatch buffer entry; tag storage width is C_DISPATCH_TAG_W.
    typedef struct packed {
        logic [C_DISPATCH_TAG_W-1:0] tag;
        logic [C_OP-1:0]             result;
        logic [C_FFLAG-1:0]          flags;
        logic                        filled;
    } fpu_dispatch_entry_t;

    // Output port lock: FREE re-arbitrates every cycle, HOLD keeps the selection.
    typedef enum logic {
        OUT_FREE = 1'b0,
        OUT_HOLD = 1'b1
    } fpu_dispatch_out_state_e;

endpackage

// File: rtl/fpu_dispatch_slot_buf.sv
// Per-unit circular tag/result buffer with alloc/fill/retire pointers.
module fpu_dispatch_slot_buf
    import fpu_defs::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          alloc_i,
    input  logic [C_DISPATCH_TAG_W-1:0]   tag_i,
    input  logic                          fill_i,
    input  logic [C_OP-1:0]               result_i,
    input  logic [C_FFLAG-1:0]            flags_i,
    input  logic                          retire_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          eligible_o,
    output logic [C_DISPATCH_TAG_W-1:0]   head_tag_o,
    output logic [C_OP-1:0]               head_result_o,
    output logic [C_FFLAG-1:0]            head_flags_o,
    output logic                          spurious_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fpu_dispatch_entry_t ent_q [DEPTH];
    logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, ret_q, ret_d;
    logic [CW-1:0] count_q, count_d, pend_q, pend_d;
    logic          fill_ok;

    // Pointer/counter next state; a completion with nothing pending is dropped.
    always_comb begin
        fill_ok    = fill_i && (pend_q != '0);
        spurious_o = fill_i && (pend_q == '0);
        alloc_d    = alloc_i  ? alloc_q + 1'b1 : alloc_q;
        fill_d     = fill_ok  ? fill_q + 1'b1  : fill_q;
        ret_d      = retire_i ? ret_q + 1'b1   : ret_q;
        count_d    = count_q + CW'(alloc_i) - CW'(retire_i);
        pend_d     = pend_q + CW'(alloc_i) - CW'(fill_ok);
    end

    // Buffer storage and pointer registers; the three ports never hit one entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_q <= '0;
            fill_q  <= '0;
            ret_q   <= '0;
            count_q <= '0;
            pend_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            ret_q   <= ret_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            if (alloc_i) begin
                ent_q[alloc_q].tag <= tag_i;
            end
            if (fill_ok) begin
                ent_q[fill_q].result <= result_i;
                ent_q[fill_q].flags  <= flags_i;
                ent_q[fill_q].filled <= 1'b1;
            end
            if (retire_i) begin
                ent_q[ret_q].filled <= 1'b0;
            end
        end
    end

    // Head-of-buffer view for the arbiter.
    always_comb begin
        count_o       = count_q;
        eligible_o    = ent_q[ret_q].filled;
        head_tag_o    = ent_q[ret_q].tag;
        head_result_o = ent_q[ret_q].result;
        head_flags_o  = ent_q[ret_q].flags;
    end

endmodule

// File: rtl/fpu_dispatch.sv
// FPU issue/retire controller. Macro FPU_DISPATCH_RR_EN selects round-robin
// retire arbitration; otherwise the lowest eligible unit index wins.
module fpu_dispatch
    import fpu_defs::*;
#(
    parameter int unsigned N_UNITS = 3,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAG_W   = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [$clog2(N_UNITS)-1:0]  in_unit_i,
    input  logic [TAG_W-1:0]            in_tag_i,
    output logic [N_UNITS-1:0]          unit_en_o,
    input  logic [N_UNITS-1:0]          unit_busy_i,
    input  logic [N_UNITS-1:0]          unit_valid_i,
    input  logic [N_UNITS*C_OP-1:0]     unit_result_i,
    input  logic [N_UNITS*C_FFLAG-1:0]  unit_flags_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [C_OP-1:0]             out_result_o,
    output logic [C_FFLAG-1:0]          out_flags_o,
    output logic [TAG_W-1:0]            out_tag_o,
    output logic [$clog2(N_UNITS)-1:0]  out_unit_o,
    output logic                        err_o
);

    localparam int unsigned UW = $clog2(N_UNITS);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [CW-1:0]               count    [N_UNITS];
    logic [C_DISPATCH_TAG_W-1:0] head_tag [N_UNITS];
    logic [C_OP-1:0]             head_res [N_UNITS];
    logic [C_FFLAG-1:0]          head_flg [N_UNITS];
    logic [N_UNITS-1:0]          elig, spur, retire;
    logic                        sel_busy, sel_full, accept, handshake, found;
    logic [UW-1:0]               pick, sel, lock_unit_q, lock_unit_d;
    logic                        err_q, err_d;
    fpu_dispatch_out_state_e     state_q, state_d;
`ifdef FPU_DISPATCH_RR_EN
    logic [UW-1:0]               rr_q, rr_d;
    int                          j;
`endif

    // One buffer per execution unit.
    for (genvar u = 0; u < int'(N_UNITS); u++) begin : g_slot
        fpu_dispatch_slot_buf #(.DEPTH(DEPTH)) u_slot (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .alloc_i       (unit_en_o[u]),
            .tag_i         (C_DISPATCH_TAG_W'(in_tag_i)),
            .fill_i        (unit_valid_i[u]),
            .result_i      (unit_result_i[u*C_OP +: C_OP]),
            .flags_i       (unit_flags_i[u*C_FFLAG +: C_FFLAG]),
            .retire_i      (retire[u]),
            .count_o       (count[u]),
            .eligible_o    (elig[u]),
            .head_tag_o    (head_tag[u]),
            .head_result_o (head_res[u]),
            .head_flags_o  (head_flg[u]),
            .spurious_o    (spur[u])
        );
    end

    // Issue decode: out-of-range unit indices fall through as busy and full.
    always_comb begin
        sel_busy  = 1'b1;
        sel_full  = 1'b1;
        unit_en_o = '0;
        for (int u = 0; u < int'(N_UNITS); u++) begin
            if (in_unit_i == UW'(u)) begin
                sel_busy = unit_busy_i[u];
                sel_full = (count[u] == CW'(DEPTH));
            end
        end
        in_ready_o = !sel_busy && !sel_full;
        accept     = in_valid_i && in_ready_o;
        for (int u = 0; u < int'(N_UNITS); u++) begin
            unit_en_o[u] = accept && (in_unit_i == UW'(u));
        end
    end

    // Retire arbiter over units whose head entry is filled.
    always_comb begin
        pick  = '0;
        found = 1'b0;
`ifdef FPU_DISPATCH_RR_EN
        j = 0;
        for (int k = 0; k < int'(N_UNITS); k++) begin
            j = int'(rr_q) + k;
            if (j >= int'(N_UNITS)) begin
                j = j - int'(N_UNITS);
            end
            if (!found && elig[j]) begin
                pick  = UW'(j);
                found = 1'b1;
            end
        end
`else
        for (int u = 0; u < int'(N_UNITS); u++) begin
            if (!found && elig[u]) begin
                pick  = UW'(u);
                found = 1'b1;
            end
        end
`endif
    end

    // Output lock FSM: a presented result is held until the consumer takes it.
    always_comb begin
        state_d     = state_q;
        lock_unit_d = lock_unit_q;
        sel         = (state_q == OUT_HOLD) ? lock_unit_q : pick;
        out_valid_o = |elig;
        handshake   = out_valid_o && out_ready_i;
        err_d       = err_q | (|spur);
        case (state_q)
            OUT_FREE: begin
                if (out_valid_o && !out_ready_i) begin
                    state_d     = OUT_HOLD;
                    lock_unit_d = sel;
                end
            end
            OUT_HOLD: begin
                if (out_ready_i) begin
                    state_d = OUT_FREE;
                end
            end
            default: state_d = OUT_FREE;
        endcase
        retire = '0;
        for (int u = 0; u < int'(N_UNITS); u++) begin
            retire[u] = handshake && (sel == UW'(u));
        end
`ifdef FPU_DISPATCH_RR_EN
        rr_d = rr_q;
        if (handshake) begin
            rr_d = (sel == UW'(N_UNITS - 1)) ? '0 : sel + 1'b1;
        end
`endif
    end

    // Output mux; outputs read zero while nothing is valid.
    always_comb begin
        out_result_o = '0;
        out_flags_o  = '0;
        out_tag_o    = '0;
        out_unit_o   = '0;
        if (out_valid_o) begin
            out_unit_o = sel;
            for (int u = 0; u < int'(N_UNITS); u++) begin
                if (sel == UW'(u)) begin
                    out_result_o = head_res[u];
                    out_flags_o  = head_flg[u];
                    out_tag_o    = TAG_W'(head_tag[u]);
                end
            end
        end
    end

    // Lock state, arbitration pointer and sticky protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= OUT_FREE;
            lock_unit_q <= '0;
            err_q       <= 1'b0;
`ifdef FPU_DISPATCH_RR_EN
            rr_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lock_unit_q <= lock_unit_d;
            err_q       <= err_d;
`ifdef FPU_DISPATCH_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign err_o = err_q;

endmodule
